// File: rtl/gb_intc.sv
// gb_intc: GameBoy IF/IE interrupt controller with RST vector supply on the ack cycle.
// Optional serviced-interrupt counters are built when GB_INTC_CNT_EN is defined.
module gb_intc #(
    parameter int          NSRC    = 5,
    parameter logic [7:0]  VECBASE = 8'h40
) (
    input  logic                CLK_n,
    input  logic                RESET_n,
    input  logic                CLKEN,
    input  logic [15:0]         A,
    input  logic [7:0]          DO,
    input  logic                MREQ_n,
    input  logic                RD_n,
    input  logic                WR_n,
    input  logic                IORQ_n,
    input  logic                M1_n,
    input  logic [NSRC-1:0]     irq_src,
    output logic                INT_n,
    output logic [7:0]          dout,
    output logic                dout_sel,
    output logic [8*NSRC-1:0]   irq_cnt
);
    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t            r_state, w_state_nxt;
    logic [NSRC-1:0]   r_if, r_hist, w_if_nxt, w_pend, w_sel, w_edge;
    logic [7:0]        r_ie, r_vec, w_vec_nxt;
    logic              r_wr_n, w_wr, w_ack_go, w_found;
    logic [2:0]        w_p;

    assign w_edge   = irq_src & ~r_hist;
    assign w_wr     = ~MREQ_n & ~WR_n & r_wr_n;
    assign w_pend   = r_if & r_ie[NSRC-1:0];
    assign w_sel    = w_pend & ~(w_pend - 1'b1);
    assign w_found  = |w_pend;
    assign w_ack_go = (r_state == S_IDLE) & ~IORQ_n & ~M1_n;

    always_comb begin
        w_p = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_pend[i]) w_p = i[2:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        if (r_state == S_IDLE && w_ack_go) begin
            w_state_nxt = S_ACK;
            w_vec_nxt   = w_found ? VECBASE + {2'b00, w_p, 3'b000} : 8'h00;
        end else if (r_state == S_ACK && IORQ_n) begin
            w_state_nxt = S_IDLE;
        end
    end

    // edge set is applied last so it wins over both a register write and an ack clear
    always_comb begin
        w_if_nxt = (w_wr && A == 16'hFF0F) ? DO[NSRC-1:0] : r_if;
        if (w_ack_go) w_if_nxt = w_if_nxt & ~w_sel;
        w_if_nxt = w_if_nxt | w_edge;
    end

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
            r_vec   <= 8'h00;
            r_if    <= '0;
            r_ie    <= 8'h00;
            r_hist  <= '1;
            r_wr_n  <= 1'b1;
            INT_n   <= 1'b1;
        end else if (CLKEN) begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_if    <= w_if_nxt;
            r_hist  <= irq_src;
            r_wr_n  <= WR_n;
            INT_n   <= ~w_found;
            if (w_wr && A == 16'hFFFF) r_ie <= DO;
        end
    end

    always_comb begin
        dout     = 8'hFF;
        dout_sel = 1'b0;
        if (r_state == S_ACK && !IORQ_n) begin
            dout     = r_vec;
            dout_sel = 1'b1;
        end else if (!MREQ_n && !RD_n && (A == 16'hFF0F || A == 16'hFFFF)) begin
            dout     = (A == 16'hFF0F) ? {{(8-NSRC){1'b1}}, r_if} : r_ie;
            dout_sel = 1'b1;
        end
    end

`ifdef GB_INTC_CNT_EN
    logic [NSRC-1:0][7:0] r_cnt;

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt <= '0;
        end else if (CLKEN && w_ack_go) begin
            for (int i = 0; i < NSRC; i++)
                if (w_sel[i] && r_cnt[i] != 8'hFF) r_cnt[i] <= r_cnt[i] + 8'd1;
        end
    end

    assign irq_cnt = r_cnt;
`else
    assign irq_cnt = '0;
`endif
endmodule

// File: tb/tb_gb_intc.sv
// tb_gb_intc: directed checks of gb_intc register access, edge detect, ack vectors and reset.
module tb_gb_intc;
    logic        CLK_n = 1'b0, RESET_n = 1'b0, CLKEN = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic        MREQ_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1, IORQ_n = 1'b1, M1_n = 1'b1;
    logic [4:0]  irq_src = 5'h1F;
    logic        INT_n, dout_sel;
    logic [7:0]  dout;
    logic [39:0] irq_cnt;
    int          total = 0, bad = 0;

    gb_intc dut (
        .CLK_n(CLK_n), .RESET_n(RESET_n), .CLKEN(CLKEN), .A(A), .DO(DO),
        .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n), .IORQ_n(IORQ_n), .M1_n(M1_n),
        .irq_src(irq_src), .INT_n(INT_n), .dout(dout), .dout_sel(dout_sel), .irq_cnt(irq_cnt)
    );

    always #5 CLK_n = ~CLK_n;

    task automatic step();
        @(posedge CLK_n);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        A = addr; DO = data; MREQ_n = 1'b0; WR_n = 1'b0;
        step();
        MREQ_n = 1'b1; WR_n = 1'b1;
        step();
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        A = addr; MREQ_n = 1'b0; RD_n = 1'b0;
        #1;
        chk({tag, "_sel"}, {39'd0, dout_sel}, 40'd1);
        chk(tag, {32'd0, dout}, {32'd0, exp});
        MREQ_n = 1'b1; RD_n = 1'b1;
        #1;
    endtask

    task automatic ack(input string tag, input logic [7:0] exp);
        IORQ_n = 1'b0; M1_n = 1'b0;
        step();
        chk({tag, "_sel"}, {39'd0, dout_sel}, 40'd1);
        chk(tag, {32'd0, dout}, {32'd0, exp});
        IORQ_n = 1'b1; M1_n = 1'b1;
        step();
    endtask

    task automatic pulse(input int src);
        irq_src[src] = 1'b1;
        step();
        irq_src[src] = 1'b0;
        step();
    endtask

    initial begin
        logic [39:0] exp_cnt;
        // 1: sources already high at reset release do not set IF
        step(); step();
        chk("rst_int_n", {39'd0, INT_n}, 40'd1);
        chk("rst_sel", {39'd0, dout_sel}, 40'd0);
        chk("rst_dout", {32'd0, dout}, 40'hFF);
        chk("rst_cnt", irq_cnt, 40'd0);
        RESET_n = 1'b1;
        step(); step();
        rd("if_after_rst", 16'hFF0F, 8'hE0);
        rd("ie_after_rst", 16'hFFFF, 8'h00);
        irq_src = 5'h1E; step();
        irq_src = 5'h1F; step();
        rd("if_src0_edge", 16'hFF0F, 8'hE1);
        irq_src = 5'h00; step();
        // CLKEN low blocks a write
        CLKEN = 1'b0;
        A = 16'hFFFF; DO = 8'h11; MREQ_n = 1'b0; WR_n = 1'b0;
        step();
        MREQ_n = 1'b1; WR_n = 1'b1;
        step();
        CLKEN = 1'b1;
        rd("ie_clken_hold", 16'hFFFF, 8'h00);
        // 2: priority vectors and INT_n latency
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h05);
        irq_src[2] = 1'b1; step();
        chk("int_n_same", {39'd0, INT_n}, 40'd1);
        irq_src[2] = 1'b0; step();
        chk("int_n_lat", {39'd0, INT_n}, 40'd0);
        pulse(0);
        rd("if_two_pend", 16'hFF0F, 8'hE5);
        ack("ack_vec0", 8'h40);
        rd("if_after_ack0", 16'hFF0F, 8'hE4);
        ack("ack_vec2", 8'h50);
        rd("if_after_ack2", 16'hFF0F, 8'hE0);
        chk("int_n_idle", {39'd0, INT_n}, 40'd1);
        // 3: nothing pending at ack time gives vector 0 and no clear
        wr(16'hFF0F, 8'h03);
        wr(16'hFFFF, 8'h01);
        chk("int_n_pend", {39'd0, INT_n}, 40'd0);
        wr(16'hFFFF, 8'h00);
        ack("ack_none", 8'h00);
        rd("if_unchanged", 16'hFF0F, 8'hE3);
        // 4: edge wins over a same-cycle IF write
        A = 16'hFF0F; DO = 8'h00; MREQ_n = 1'b0; WR_n = 1'b0; irq_src = 5'h08;
        step();
        MREQ_n = 1'b1; WR_n = 1'b1; irq_src = 5'h00;
        step();
        rd("if_edge_wins", 16'hFF0F, 8'hE8);
        wr(16'hFFFF, 8'hA5);
        rd("ie_a5", 16'hFFFF, 8'hA5);
        // 5: reset during ACK
        wr(16'hFF0F, 8'h01);
        wr(16'hFFFF, 8'h01);
        IORQ_n = 1'b0; M1_n = 1'b0;
        step();
        chk("ack5_sel", {39'd0, dout_sel}, 40'd1);
        chk("ack5_vec", {32'd0, dout}, 40'h40);
        RESET_n = 1'b0;
        #1;
        chk("rst_ack_sel", {39'd0, dout_sel}, 40'd0);
        chk("rst_ack_int_n", {39'd0, INT_n}, 40'd1);
        chk("rst_ack_cnt", irq_cnt, 40'd0);
        IORQ_n = 1'b1; M1_n = 1'b1;
        step();
        RESET_n = 1'b1;
        step();
        rd("if_rst_ack", 16'hFF0F, 8'hE0);
        rd("ie_rst_ack", 16'hFFFF, 8'h00);
        // 6: serviced counter saturation
        wr(16'hFFFF, 8'h04);
        for (int n = 0; n < 300; n++) begin
            pulse(2);
            IORQ_n = 1'b0; M1_n = 1'b0;
            step();
            IORQ_n = 1'b1; M1_n = 1'b1;
            step();
        end
`ifdef GB_INTC_CNT_EN
        exp_cnt = 40'h00_00_FF_00_00;
`else
        exp_cnt = 40'h0;
`endif
        chk("cnt_sat", irq_cnt, exp_cnt);
        ack("ack_timer_empty", 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
